// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces a vector of raw key inputs.
// Each bit passes through a two-flop synchroniser and then a stability
// counter. The clean level flips only after the synchronised level has
// disagreed with it for STABLE_CYCLES consecutive clocks. Any single
// agreeing cycle restarts the count, which rejects contact bounce.
// Registered press/release strobes mark each clean edge for one cycle.

module key_debounce #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:1]   key_raw,
  output logic [WIDTH:1]   key_clean,
  output logic [WIDTH:1]   key_press,
  output logic [WIDTH:1]   key_release,
  output logic             key_change
);

  // Counter width is derived from the hold time and is not overridable.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // Terminal count: on this value a further mismatch flips the clean level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Synchroniser stages; only sync2_q feeds the filter.
  logic [WIDTH:1]            sync1_q;
  logic [WIDTH:1]            sync2_q;

  // Per-bit stability counters, packed so they reset and default as one word.
  logic [WIDTH:1][CNT_W-1:0] cnt_q;
  logic [WIDTH:1][CNT_W-1:0] cnt_d;

  // Clean level and one-cycle edge strobes, all registered.
  logic [WIDTH:1]            key_clean_q;
  logic [WIDTH:1]            key_clean_d;
  logic [WIDTH:1]            key_press_q;
  logic [WIDTH:1]            key_press_d;
  logic [WIDTH:1]            key_release_q;
  logic [WIDTH:1]            key_release_d;
  logic                      key_change_q;
  logic                      key_change_d;

  // Two-flop synchroniser bringing the asynchronous keys into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit filter: count consecutive mismatches, flip and strobe on the last one.
  always_comb begin
    key_clean_d   = key_clean_q;
    key_press_d   = '0;
    key_release_d = '0;
    cnt_d         = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (sync2_q[i] != key_clean_q[i]) begin
        // The >= guard keeps the counter pinned at its terminal value even
        // if an upset ever pushed it past, so it can never wrap.
        if (cnt_q[i] >= CNT_LAST) begin
          key_clean_d[i]   = sync2_q[i];
          key_press_d[i]   = sync2_q[i];
          key_release_d[i] = ~sync2_q[i];
          cnt_d[i]         = CNT_ZERO;
        end else begin
          cnt_d[i]         = cnt_q[i] + CNT_ONE;
        end
      end else begin
        // A matching cycle is the glitch-rejection point: restart the count.
        cnt_d[i] = CNT_ZERO;
      end
    end
    // Several bits may flip together; they still produce one change pulse.
    key_change_d = |(key_press_d | key_release_d);
  end

  // Filter state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      key_clean_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_change_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      key_clean_q   <= key_clean_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_change_q  <= key_change_d;
    end
  end

  assign key_clean   = key_clean_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_change  = key_change_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce with
// STABLE_CYCLES=4 against a sliding-window reference model.

module tb_key_debounce;

  localparam int W = 4;
  localparam int S = 4;

  logic         clk;
  logic         rst;
  logic [W:1]   key_raw;
  logic [W:1]   key_clean;
  logic [W:1]   key_press;
  logic [W:1]   key_release;
  logic         key_change;

  int tests;
  int fails;

  key_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_clean   (key_clean),
    .key_press   (key_press),
    .key_release (key_release),
    .key_change  (key_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // dq: the two synchroniser stages as a delay line (dq[0] is the older one).
  // win: the last S synchronised samples seen by the filter. A bit flips when
  // every sample in a full window disagrees with its current clean level.
  logic [W:1] dq[$];
  logic [W:1] win[$];
  logic [W:1] m_clean, m_press, m_rel;
  logic       m_chg;

  task automatic model_reset();
    dq.delete();
    dq.push_back('0);
    dq.push_back('0);
    win.delete();
    m_clean = '0;
    m_press = '0;
    m_rel   = '0;
    m_chg   = 1'b0;
  endtask

  task automatic model_edge(input logic [W:1] raw);
    logic [W:1] s;
    logic [W:1] flip;
    s = dq.pop_front();
    dq.push_back(raw);
    win.push_back(s);
    if (win.size() > S) void'(win.pop_front());
    flip = '0;
    if (win.size() == S) begin
      for (int b = 1; b <= W; b++) begin
        int agree;
        agree = 0;
        foreach (win[j]) if (win[j][b] == m_clean[b]) agree++;
        if (agree == 0) flip[b] = 1'b1;
      end
    end
    m_press = flip & s;
    m_rel   = flip & ~s;
    m_chg   = |flip;
    m_clean = m_clean ^ flip;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W:1] obs, input logic [W:1] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".clean"},   key_clean,          m_clean);
    chk({tag, ".press"},   key_press,          m_press);
    chk({tag, ".release"}, key_release,        m_rel);
    chk({tag, ".change"},  {3'b000, key_change}, {3'b000, m_chg});
  endtask

  // One clock: capture the level present before the edge, advance model, compare.
  task automatic tick(input string tag);
    logic [W:1] raw_pre;
    raw_pre = key_raw;
    @(posedge clk);
    model_edge(raw_pre);
    #1;
    chk_model(tag);
  endtask

  task automatic hold(input logic [W:1] v, input int n, input string tag);
    key_raw = v;
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  initial begin
    logic [W:1] v;
    logic [W:1] prev;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    key_raw = '0;
    model_reset();

    // Reset state
    #1;
    chk("rst.clean",   key_clean,   4'b0000);
    chk("rst.press",   key_press,   4'b0000);
    chk("rst.release", key_release, 4'b0000);
    chk("rst.change",  {3'b000, key_change}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // 1: single key press, flips on edge 6
    key_raw = 4'b0001;
    for (int k = 1; k <= 5; k++) tick("t1");
    chk("t1.e5.clean", key_clean, 4'b0000);
    tick("t1");
    chk("t1.e6.clean", key_clean, 4'b0001);
    chk("t1.e6.press", key_press, 4'b0001);
    chk("t1.e6.change", {3'b000, key_change}, 4'b0001);
    tick("t1");
    chk("t1.e7.press", key_press, 4'b0000);
    chk("t1.e7.change", {3'b000, key_change}, 4'b0000);
    hold(4'b0000, 10, "t1.back");

    // 2: bit1 bouncing every 2 cycles never gets through
    for (int k = 0; k < 10; k++) begin
      v = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      hold(v, 2, "t2");
      chk("t2.clean", key_clean, 4'b0000);
    end
    hold(4'b0000, 8, "t2.end");

    // 3: all four keys at once
    key_raw = 4'b1111;
    for (int k = 1; k <= 6; k++) tick("t3");
    chk("t3.e6.clean", key_clean, 4'b1111);
    chk("t3.e6.press", key_press, 4'b1111);
    hold(4'b1111, 2, "t3.hold");

    // 4: 1010 -> 0110 gives mixed press/release
    hold(4'b1010, 8, "t4.pre");
    chk("t4.pre.clean", key_clean, 4'b1010);
    key_raw = 4'b0110;
    for (int k = 1; k <= 6; k++) tick("t4");
    chk("t4.e6.clean",   key_clean,   4'b0110);
    chk("t4.e6.press",   key_press,   4'b0100);
    chk("t4.e6.release", key_release, 4'b1000);
    chk("t4.e6.change",  {3'b000, key_change}, 4'b0001);
    tick("t4");

    // 5: asynchronous reset mid-count
    key_raw = 4'b0001;
    for (int k = 1; k <= 4; k++) tick("t5");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5.rst.clean",   key_clean,   4'b0000);
    chk("t5.rst.press",   key_press,   4'b0000);
    chk("t5.rst.release", key_release, 4'b0000);
    chk("t5.rst.change",  {3'b000, key_change}, 4'b0000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) tick("t5.post");
    chk("t5.e5.clean", key_clean, 4'b0000);
    tick("t5.post");
    chk("t5.e6.clean", key_clean, 4'b0001);
    hold(4'b0000, 8, "t5.back");

    // 6: ascending sweep, each value held 10 cycles
    prev = key_clean;
    for (int n = 0; n < 16; n++) begin
      v = W'(n);
      key_raw = v;
      for (int k = 1; k <= 10; k++) begin
        tick("t6");
        if (k == 5) chk("t6.e5.clean", key_clean, prev);
        if (k == 6) chk("t6.e6.clean", key_clean, v);
      end
      prev = v;
    end

    // Randomized bouncing traffic against the model
    for (int n = 0; n < 60; n++) begin
      v = W'($urandom_range(0, 15));
      hold(v, $urandom_range(1, 8), "rnd");
    end

    // Reset while outputs may be non-zero, then recover
    hold(4'b1011, 8, "rnd.settle");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rnd.rst.clean", key_clean, 4'b0000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    hold(4'b1011, 8, "rnd.recover");
    chk("rnd.recover.clean", key_clean, 4'b1011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
